// File: rtl/bus_test_responder_if.sv
// Memory-bus handshake bundle between a bus master and the test responder.
// The master raises strobe and holds the request until ready pulses.
interface bus_test_responder_if #(
    parameter int ADDRESS_SIZE = 16,
    parameter int DATA_SIZE    = 32
);
    logic                    strobe;
    logic                    writeEnable;
    logic [ADDRESS_SIZE-1:0] address;
    logic [DATA_SIZE-1:0]    dataWrite;
    logic [DATA_SIZE-1:0]    dataRead;
    logic                    ready;

    modport master (
        output strobe, writeEnable, address, dataWrite,
        input  dataRead, ready
    );

    modport slave (
        input  strobe, writeEnable, address, dataWrite,
        output dataRead, ready
    );
endinterface

// File: rtl/bus_test_responder.sv
// Bus responder for core bring-up: programmable wait states, echo store or LFSR
// read data, sticky interrupt register, transaction count and MISR signature.
module bus_test_responder #(
    parameter int                      ADDRESS_SIZE = 16,
    parameter int                      DATA_SIZE    = 32,
    parameter int                      DEPTH_LOG2   = 4,
    parameter int                      SIG_SIZE     = 8,
    parameter int                      WAIT_BITS    = 4,
    parameter int                      IRQ_COUNT    = 4,
    parameter logic [ADDRESS_SIZE-1:0] IRQ_ADDRESS  = 16'hFFF0
) (
    input  logic                 clock,
    input  logic                 reset,
    bus_test_responder_if.slave  bus,
    input  logic                 mode,
    input  logic [WAIT_BITS-1:0] waitStates,
    input  logic [IRQ_COUNT-1:0] irqAck,
    output logic [IRQ_COUNT-1:0] interruptReq,
    output logic [SIG_SIZE-1:0]  signature,
    output logic [15:0]          txCount,
    output logic                 protocolError
);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                  state;
    logic [ADDRESS_SIZE-1:0] lat_addr;
    logic [DATA_SIZE-1:0]    lat_data;
    logic                    lat_we;
    logic                    lat_mode;
    logic [WAIT_BITS-1:0]    count;
    logic [15:0]             lfsr;
    logic [DATA_SIZE-1:0]    store [2**DEPTH_LOG2];

    logic [ADDRESS_SIZE-1:0] req_addr;
    logic                    req_mode;
    logic [DATA_SIZE-1:0]    read_value;
    logic [DATA_SIZE-1:0]    ack_data;
    logic [SIG_SIZE-1:0]     sig_next;
    logic [15:0]             lfsr_next;
    logic                    irq_write;

    function automatic logic [SIG_SIZE-1:0] fold_data(input logic [DATA_SIZE-1:0] x);
        logic [SIG_SIZE-1:0] f;
        f = '0;
        for (int i = 0; i < DATA_SIZE; i++) f[i % SIG_SIZE] ^= x[i];
        return f;
    endfunction

    function automatic logic [SIG_SIZE-1:0] fold_addr(input logic [ADDRESS_SIZE-1:0] x);
        logic [SIG_SIZE-1:0] f;
        f = '0;
        for (int i = 0; i < ADDRESS_SIZE; i++) f[i % SIG_SIZE] ^= x[i];
        return f;
    endfunction

    // Read data is captured on the edge entering ACK; in IDLE the request is
    // still on the bus, afterwards only the latched copy is trusted.
    always_comb begin
        req_addr = (state == S_IDLE) ? bus.address : lat_addr;
        req_mode = (state == S_IDLE) ? mode        : lat_mode;
        if (req_addr == IRQ_ADDRESS)
            read_value = DATA_SIZE'(interruptReq);
        else if (req_mode)
            read_value = {(DATA_SIZE/16){lfsr}};
        else
            read_value = store[req_addr[DEPTH_LOG2-1:0]];
    end

    assign irq_write = lat_we && (lat_addr == IRQ_ADDRESS);
    assign ack_data  = lat_we ? lat_data : bus.dataRead;
    assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign sig_next  = ((signature >> 1) | (signature << (SIG_SIZE-1)))
                     ^ fold_data(ack_data) ^ fold_addr(lat_addr)
                     ^ (SIG_SIZE'(lat_we) << (SIG_SIZE-1));

    // NOTE: non-blocking assignments so every register sees pre-edge values;
    // a later assignment in the same branch overrides the defaults above it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            bus.ready     <= 1'b0;
            bus.dataRead  <= '0;
            interruptReq  <= '0;
            signature     <= '0;
            txCount       <= '0;
            protocolError <= 1'b0;
            lfsr          <= LFSR_SEED;
            lat_addr      <= '0;
            lat_data      <= '0;
            lat_we        <= 1'b0;
            lat_mode      <= 1'b0;
            count         <= '0;
        end else begin
            bus.ready    <= 1'b0;
            interruptReq <= interruptReq & ~irqAck;
            unique case (state)
                S_IDLE: if (bus.strobe) begin
                    lat_addr <= bus.address;
                    lat_data <= bus.dataWrite;
                    lat_we   <= bus.writeEnable;
                    lat_mode <= mode;
                    if (waitStates == '0) begin
                        state     <= S_ACK;
                        bus.ready <= 1'b1;
                        if (!bus.writeEnable) bus.dataRead <= read_value;
                    end else begin
                        count <= waitStates - 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.strobe) begin
                        protocolError <= 1'b1;
                        state         <= S_IDLE;
                    end else if (count == '0) begin
                        state     <= S_ACK;
                        bus.ready <= 1'b1;
                        if (!lat_we) bus.dataRead <= read_value;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                S_ACK: begin
                    state     <= S_IDLE;
                    txCount   <= txCount + 16'd1;
                    signature <= sig_next;
                    // Set beats a same-cycle acknowledge on the same bit.
                    if (irq_write)
                        interruptReq <= (interruptReq & ~irqAck) | lat_data[IRQ_COUNT-1:0];
                    if (!lat_we && lat_mode) lfsr <= lfsr_next;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the store is deliberately not reset; it maps to plain RAM and its
    // contents are undefined until written. Reset still blocks a pending write.
    always_ff @(posedge clock) begin
        if (!reset && state == S_ACK && lat_we && lat_addr != IRQ_ADDRESS)
            store[lat_addr[DEPTH_LOG2-1:0]] <= lat_data;
    end
endmodule

// File: tb/tb_bus_test_responder.sv
// Directed bench for bus_test_responder: a transaction-level model predicts every
// output each cycle, and literal expectations pin the model's key results.
module tb_bus_test_responder;
    localparam logic [15:0] IRQ_ADDR = 16'hFFF0;

    logic        clock = 1'b0;
    logic        reset;
    logic        mode;
    logic [3:0]  waitStates;
    logic [3:0]  irqAck;
    logic [3:0]  interruptReq;
    logic [7:0]  signature;
    logic [15:0] txCount;
    logic        protocolError;

    bus_test_responder_if #(.ADDRESS_SIZE(16), .DATA_SIZE(32)) bus ();

    bus_test_responder dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .mode         (mode),
        .waitStates   (waitStates),
        .irqAck       (irqAck),
        .interruptReq (interruptReq),
        .signature    (signature),
        .txCount      (txCount),
        .protocolError(protocolError)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the visible state.
    logic [31:0] m_mem [16];
    logic [3:0]  m_irq;
    logic [15:0] m_cnt;
    logic [7:0]  m_sig;
    logic        m_perr;
    logic [31:0] m_dread;
    logic [15:0] m_lfsr;
    int          exp_ready_cyc = -1;
    bit          chk_en = 1'b0;

    function automatic logic [7:0] fold32(input logic [31:0] x);
        logic [7:0] f = 8'h00;
        for (int k = 0; k < 32; k += 8) f ^= x[k +: 8];
        return f;
    endfunction

    function automatic logic [7:0] fold16(input logic [15:0] x);
        return x[15:8] ^ x[7:0];
    endfunction

    task automatic model_reset();
        m_irq = '0; m_cnt = '0; m_sig = '0; m_perr = 1'b0;
        m_dread = '0; m_lfsr = 16'hACE1; exp_ready_cyc = -1;
    endtask

    function automatic logic [31:0] model_read(input logic [15:0] a, input logic md);
        if (a == IRQ_ADDR) return {28'b0, m_irq};
        if (md)            return {m_lfsr, m_lfsr};
        return m_mem[a[3:0]];
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            check("ready", bus.ready, cyc == exp_ready_cyc);
            check("dataRead", bus.dataRead, m_dread);
            check("interruptReq", interruptReq, m_irq);
            check("txCount", txCount, m_cnt);
            check("signature", signature, m_sig);
            check("protocolError", protocolError, m_perr);
        end
    end

    // Full transaction; alt is placed on the request lines after accept.
    task automatic txn(input logic we, input logic [15:0] a, input logic [31:0] d,
                       input logic md, input int ws, input logic [15:0] alt,
                       input logic [3:0] ack);
        logic [31:0] rd;
        logic [3:0]  set;
        int          start;
        @(posedge clock); #1;
        bus.strobe = 1'b1; bus.writeEnable = we; bus.address = a; bus.dataWrite = d;
        mode = md; waitStates = 4'(ws);
        start = cyc;
        exp_ready_cyc = start + 1 + ws;
        rd = model_read(a, md);
        while (cyc < start + 1 + ws) begin
            @(posedge clock); #1;
            bus.address = alt; bus.dataWrite = ~d; bus.writeEnable = ~we; mode = ~md;
        end
        bus.strobe = 1'b0;
        irqAck = ack;
        if (!we) m_dread = rd;
        @(posedge clock); #1;
        irqAck = '0;
        set = (we && a == IRQ_ADDR) ? d[3:0] : 4'b0;
        if (we && a != IRQ_ADDR) m_mem[a[3:0]] = d;
        if (!we && md) m_lfsr = {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
        m_irq = (m_irq & ~ack) | set;
        m_sig = {m_sig[0], m_sig[7:1]} ^ fold32(we ? d : rd) ^ fold16(a) ^ {we, 7'b0};
        m_cnt = m_cnt + 16'd1;
        exp_ready_cyc = -1;
    endtask

    // Write that is cut short after two cycles, by a strobe drop or by reset.
    task automatic broken_write(input logic [15:0] a, input logic [31:0] d,
                                input int ws, input bit use_reset);
        @(posedge clock); #1;
        bus.strobe = 1'b1; bus.writeEnable = 1'b1; bus.address = a; bus.dataWrite = d;
        mode = 1'b0; waitStates = 4'(ws);
        exp_ready_cyc = -1;
        repeat (2) begin @(posedge clock); #1; end
        bus.strobe = 1'b0;
        if (use_reset) reset = 1'b1;
        @(posedge clock); #1;
        if (use_reset) begin model_reset(); reset = 1'b0; end
        else m_perr = 1'b1;
    endtask

    task automatic pulse_ack(input logic [3:0] v);
        @(posedge clock); #1;
        irqAck = v;
        @(posedge clock); #1;
        irqAck = '0;
        m_irq = m_irq & ~v;
    endtask

    initial begin
        bus.strobe = 1'b0; bus.writeEnable = 1'b0; bus.address = '0; bus.dataWrite = '0;
        mode = 1'b0; waitStates = '0; irqAck = '0; reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        chk_en = 1'b1;
        reset = 1'b0;
        check("reset_ready", bus.ready, 1'b0);
        check("reset_count", txCount, 16'h0);

        // Write/readback with zero wait states; signature from a clean reset.
        txn(1, 16'h0005, 32'hDEADBEEF, 0, 0, 16'h0005, 4'b0);
        check("sig_after_first_write", signature, 8'hA7);
        txn(0, 16'h0005, 32'h0, 0, 0, 16'h0005, 4'b0);
        check("readback", bus.dataRead, 32'hDEADBEEF);
        check("count_two", txCount, 16'd2);

        // Aliased index shares a word.
        txn(1, 16'h0015, 32'h1, 0, 0, 16'h0015, 4'b0);
        txn(0, 16'h0005, 32'h0, 0, 0, 16'h0005, 4'b0);
        check("alias_read", bus.dataRead, 32'h00000001);

        // Wait states with request lines disturbed after accept.
        txn(1, 16'h0007, 32'hCAFEF00D, 0, 3, 16'h0009, 4'b0);
        txn(0, 16'h0007, 32'h0, 0, 15, 16'h0005, 4'b0);
        check("latched_addr_read", bus.dataRead, 32'hCAFEF00D);

        // Interrupt register: set, readback, ack, set-vs-ack on bit 2.
        txn(1, IRQ_ADDR, 32'h5, 0, 0, IRQ_ADDR, 4'b0);
        check("irq_set", interruptReq, 4'b0101);
        txn(0, IRQ_ADDR, 32'h0, 0, 1, IRQ_ADDR, 4'b0);
        check("irq_read", bus.dataRead, 32'h5);
        pulse_ack(4'b0001);
        check("irq_ack", interruptReq, 4'b0100);
        txn(1, IRQ_ADDR, 32'h4, 0, 0, IRQ_ADDR, 4'b0100);
        check("irq_set_wins", interruptReq, 4'b0100);

        // Abort during WAIT leaves the store alone and flags the error.
        broken_write(16'h0005, 32'h0BADF00D, 4, 1'b0);
        check("abort_flag", protocolError, 1'b1);
        txn(0, 16'h0005, 32'h0, 0, 0, 16'h0005, 4'b0);
        check("abort_store", bus.dataRead, 32'h00000001);

        // Reset during WAIT of a write: everything back to reset values.
        broken_write(16'h0005, 32'h12345678, 5, 1'b1);
        check("rst_mid_count", txCount, 16'h0);
        check("rst_mid_perr", protocolError, 1'b0);
        check("rst_mid_irq", interruptReq, 4'b0);
        check("rst_mid_data", bus.dataRead, 32'h0);

        // Random mode from a fresh seed, then the store is still intact.
        txn(0, 16'h0003, 32'h0, 1, 0, 16'h0003, 4'b0);
        check("lfsr_first", bus.dataRead, 32'hACE1ACE1);
        txn(0, 16'h0003, 32'h0, 1, 2, 16'h0003, 4'b0);
        check("lfsr_second", bus.dataRead, 32'h56705670);
        txn(0, 16'h0005, 32'h0, 0, 0, 16'h0005, 4'b0);
        check("store_after_rst", bus.dataRead, 32'h00000001);

        repeat (2) @(posedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end
endmodule

// File: doc/bus_test_responder.md
# bus_test_responder

Parametrised memory-bus responder and activity monitor for bring-up of the RISC-V core on the Tang Nano. It replaces the ad-hoc sink/drain stub at top level. It answers `IMemoryBus`-style transactions with programmable wait states and backs them with a small echo store or a pseudo-random data source. It also drives a programmable interrupt vector and exposes a transaction signature, a transaction count and a protocol-error flag for the debug LEDs.

## Interface
- `ADDRESS_SIZE`, 16: bus address width.
- `DATA_SIZE`, 32: bus data width; multiple of 16, ≥ 16.
- `DEPTH_LOG2`, 4: log2 of echo-store words; store indexed by `address[DEPTH_LOG2-1:0]`.
- `SIG_SIZE`, 8: signature width; ≤ `DATA_SIZE`.
- `WAIT_BITS`, 4: width of `waitStates`.
- `IRQ_COUNT`, 4: interrupt channels; ≤ `DATA_SIZE`.
- `IRQ_ADDRESS`, 16'hFFF0: address of the interrupt register.

Ports:
- `clock`  in  1: single clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high.
- `strobe`  in  1: master request valid.
- `writeEnable`  in  1: 1 = write, 0 = read.
- `address`  in  `ADDRESS_SIZE`: request address.
- `dataWrite`  in  `DATA_SIZE`: write data.
- `dataRead`  out  `DATA_SIZE`: read data; valid while `ready`.
- `ready`  out  1: one-cycle completion pulse, registered.
- `mode`  in  1: 0 = echo store, 1 = random read data; sampled at accept.
- `waitStates`  in  `WAIT_BITS`: extra latency cycles; sampled at accept.
- `irqAck`  in  `IRQ_COUNT`: per-bit clear of `interruptReq`.
- `interruptReq`  out  `IRQ_COUNT`: sticky interrupt requests.
- `signature`  out  `SIG_SIZE`: running transaction signature (MISR).
- `txCount`  out  16: completed transactions; wraps at 16'hFFFF→0.
- `protocolError`  out  1: sticky; set on aborted transaction.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE, `strobe`=1: latch `address`, `dataWrite`, `writeEnable`, `mode`, `waitStates` (accept). Go to ACK if `waitStates`=0. Otherwise load counter = `waitStates`-1 and go to WAIT.
- WAIT: if `strobe`=0, set `protocolError`, go to IDLE with no side effects. Else if counter=0, go to ACK. Else decrement the counter.
- Request inputs changing during WAIT are ignored; the latched copies are used.
- ACK: `ready`=1 for this cycle only, then IDLE. On the next edge IDLE samples `strobe` again, so back-to-back transactions are allowed.
- ACK side effects, applied at the edge ending ACK:
  - Write to `IRQ_ADDRESS`: `interruptReq` |= `dataWrite[IRQ_COUNT-1:0]`. The store is not written.
  - Other write: store[index] <= data.
  - Read, `mode`=0: `dataRead` = store[index]. Read of `IRQ_ADDRESS` returns `interruptReq` zero-extended, in either mode.
  - Read, `mode`=1: `dataRead` = LFSR state replicated `DATA_SIZE/16` times. The LFSR then advances one step.
  - All: `txCount` += 1; the signature is updated.
- LFSR: 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, shifts right, seed 16'hACE1. It advances only on random-mode read ACKs.
- Signature update: sig <= ror1(sig) ^ fold(data) ^ fold(address) ^ (`writeEnable` << (`SIG_SIZE`-1)).
  - data is the write data for writes and the returned read data for reads.
  - fold(x) = XOR of `SIG_SIZE`-bit slices of x, top slice zero-padded.
- `irqAck` is applied every cycle: `interruptReq` &= ~`irqAck`. If a set and an ack hit the same bit in the same cycle, the set wins.
- Indices alias: addresses that differ only above bit `DEPTH_LOG2`-1 share a word.

## Timing
- Strobe first high in cycle N, in IDLE → `ready` high in cycle N+1+`waitStates`.
- `dataRead` is registered and valid only while `ready`=1; outside ACK it holds its last value.
- `interruptReq`, `txCount` and `signature` change in the cycle after ACK.
- Minimum transaction period is 2 cycles.
- Reset values: `ready`=0, `dataRead`=0, `interruptReq`=0, `signature`=0, `txCount`=0, `protocolError`=0, state IDLE, LFSR=16'hACE1.
- The store is not reset; its contents are undefined until written.
- Reset asserted mid-transaction:
  - State returns to IDLE and `ready` is 0 in the next cycle.
  - The pending write is dropped.
  - Reset overrides a simultaneous ACK, so none of the ACK side effects occur.
- `protocolError` clears only on reset.

## Test plan
Default parameters unless noted.
- Write/readback, `waitStates`=0:
  - Stimulus: write 32'hDEADBEEF to 16'h0005, then read 16'h0005.
  - Required: `ready` in cycle N+1 each time; read returns 32'hDEADBEEF; `txCount`=2.
- Wait states:
  - Stimulus: `waitStates`=3; change `address` during WAIT.
  - Required: `ready` in cycle N+4; the latched address is used.
  - Stimulus: `waitStates`=15.
  - Required: `ready` in cycle N+16.
- Signature and aliasing:
  - Stimulus: after reset, write 32'hDEADBEEF to 16'h0005.
  - Required: `signature`=8'hA7.
  - Stimulus: then write 32'h1 to 16'h0015 and read 16'h0005.
  - Required: read returns 32'h00000001.
- Random mode:
  - Stimulus: after reset, two reads with `mode`=1.
  - Required: first returns 32'hACE1ACE1; second returns the next LFSR state replicated; store unchanged.
- Interrupts:
  - Stimulus: write 32'h5 to 16'hFFF0.
  - Required: `interruptReq`=4'b0101.
  - Stimulus: `irqAck`=4'b0001 for one cycle.
  - Required: `interruptReq`=4'b0100.
  - Stimulus: a set and an ack on bit 2 in the same cycle.
  - Required: bit 2 stays 1.
- Abort and reset:
  - Stimulus: `waitStates`=4; drop `strobe` after 2 cycles.
  - Required: `ready` never high, `protocolError`=1, store unchanged.
  - Stimulus: assert `reset` during WAIT of a write.
  - Required: all outputs at reset values next cycle; the write is not performed.
